// File: rtl/fmc_adc_acq_core.sv
// fmc_adc_acq_core
// Triggered multi-channel acquisition engine for the FMC ADC 250M cards. Words of
// N_CH packed samples go into a circular on-chip buffer. A pre/post trigger window
// is captured on an external edge, software or level trigger. The window is then
// replayed over a valid/ready stream. Everything runs in the sys_clk domain.
//
// Ports
//   sys_clk, rst_n     clock and synchronous active-low reset
//   adc_data/adc_valid incoming sample word (channel k at [k*SAMPLE_W +: SAMPLE_W])
//   trigger            asynchronous external trigger level
//   arm/abort/sw_trig  single-cycle control pulses
//   trig_src, trig_ch, threshold, pre_samples, post_samples
//                      capture configuration, latched on arm
//   rd_data/rd_valid/rd_ready/rd_last
//                      readout stream of the captured window
//   trig_addr          buffer address holding the trigger sample
//   busy, done         engine active / one-cycle end-of-readout pulse
//
// DEPTH_LOG2 must be at least 2.
module fmc_adc_acq_core #(
  parameter int N_CH       = 4,
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int CH_SEL_W   = 2
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [N_CH*SAMPLE_W-1:0]   adc_data,
  input  logic                       adc_valid,
  input  logic                       trigger,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       sw_trig,
  input  logic [1:0]                 trig_src,
  input  logic [CH_SEL_W-1:0]        trig_ch,
  input  logic [SAMPLE_W-1:0]        threshold,
  input  logic [DEPTH_LOG2-1:0]      pre_samples,
  input  logic [DEPTH_LOG2:0]        post_samples,
  output logic [N_CH*SAMPLE_W-1:0]   rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic                       rd_last,
  output logic [DEPTH_LOG2-1:0]      trig_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int WORD_W = N_CH * SAMPLE_W;
  localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_READ
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH_LOG2-1:0]      wptr_q, wptr_d;
  logic [1:0]                 cfg_src_q, cfg_src_d;
  logic [CH_SEL_W-1:0]        cfg_ch_q, cfg_ch_d;
  logic signed [SAMPLE_W-1:0] cfg_thr_q, cfg_thr_d;
  logic [DEPTH_LOG2-1:0]      cfg_pre_q, cfg_pre_d;
  logic [DEPTH_LOG2:0]        cfg_post_q, cfg_post_d;
  logic [DEPTH_LOG2-1:0]      pre_cnt_q, pre_cnt_d;
  logic [DEPTH_LOG2:0]        post_cnt_q, post_cnt_d;
  logic                       trig_pend_q, trig_pend_d;
  logic signed [SAMPLE_W-1:0] prev_q, prev_d;
  logic                       prev_vld_q, prev_vld_d;
  logic [DEPTH_LOG2-1:0]      trig_addr_q, trig_addr_d;
  logic [DEPTH_LOG2-1:0]      rd_addr_q, rd_addr_d;
  logic [DEPTH_LOG2:0]        rd_left_q, rd_left_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       rd_last_q, rd_last_d;
  logic                       done_q, done_d;
  logic                       ext_s1_q, ext_s1_d;
  logic                       ext_s2_q, ext_s2_d;
  logic                       ext_s3_q, ext_s3_d;
  logic                       ext_evt_q, ext_evt_d;
  logic [WORD_W-1:0]          rd_data_q;

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  logic                       mem_we;
  logic                       rd_load;
  logic                       trig_evt;
  logic                       trig_hit;
  logic                       level_rise;
  logic                       level_fall;
  logic signed [SAMPLE_W-1:0] cur_sample;
  logic [DEPTH_LOG2:0]        post_room;
  logic [DEPTH_LOG2:0]        post_clip;

  // The post window can never be larger than the space left after the pre window,
  // and a zero request still has to hold the trigger sample itself.
  assign post_room = DEPTH - {1'b0, pre_samples};

  always_comb begin
    post_clip = post_room;
    if (post_samples < post_room) begin
      post_clip = post_samples;
    end
    if (post_clip == '0) begin
      post_clip = CNT_ONE;
    end
  end

  // Select the monitored channel with an explicit compare so that an out-of-range
  // trig_ch reads as zero instead of indexing past the word.
  always_comb begin
    cur_sample = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cfg_ch_q == CH_SEL_W'(k)) begin
        cur_sample = adc_data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Level crossings need a previous valid sample, so the first word after arm only primes prev.
  assign level_rise = prev_vld_q && (prev_q < cfg_thr_q) && (cfg_thr_q <= cur_sample);
  assign level_fall = prev_vld_q && (prev_q >= cfg_thr_q) && (cfg_thr_q > cur_sample);

  always_comb begin
    trig_evt = 1'b0;
    case (cfg_src_q)
      2'd0:    trig_evt = ext_evt_q;
      2'd1:    trig_evt = sw_trig;
      2'd2:    trig_evt = adc_valid && level_rise;
      default: trig_evt = adc_valid && level_fall;
    endcase
  end

  // A trigger seen on a cycle without a valid word is held so the next valid word becomes the trigger sample.
  assign trig_hit = adc_valid && (trig_evt || trig_pend_q);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cfg_src_d   = cfg_src_q;
    cfg_ch_d    = cfg_ch_q;
    cfg_thr_d   = cfg_thr_q;
    cfg_pre_d   = cfg_pre_q;
    cfg_post_d  = cfg_post_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_pend_d = trig_pend_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    trig_addr_d = trig_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    rd_load     = 1'b0;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    ext_s1_d  = trigger;
    ext_s2_d  = ext_s1_q;
    ext_s3_d  = ext_s2_q;
    ext_evt_d = ext_s2_q && !ext_s3_q;

    if ((state_q == ST_PRE || state_q == ST_WAIT || state_q == ST_POST) && adc_valid) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + PTR_ONE;
    end

    if ((state_q == ST_PRE || state_q == ST_WAIT) && adc_valid) begin
      prev_d     = cur_sample;
      prev_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          cfg_src_d   = trig_src;
          cfg_ch_d    = trig_ch;
          cfg_thr_d   = threshold;
          cfg_pre_d   = pre_samples;
          cfg_post_d  = post_clip;
          pre_cnt_d   = '0;
          post_cnt_d  = '0;
          trig_pend_d = 1'b0;
          prev_vld_d  = 1'b0;
          state_d     = (pre_samples == '0) ? ST_WAIT : ST_PRE;
        end
      end

      ST_PRE: begin
        if (adc_valid) begin
          pre_cnt_d = pre_cnt_q + PTR_ONE;
          if (pre_cnt_q + PTR_ONE == cfg_pre_q) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (trig_hit) begin
          trig_addr_d = wptr_q;
          rd_addr_d   = wptr_q - cfg_pre_q;
          rd_left_d   = {1'b0, cfg_pre_q} + cfg_post_q;
          post_cnt_d  = CNT_ONE;
          trig_pend_d = 1'b0;
          state_d     = (cfg_post_q == CNT_ONE) ? ST_READ : ST_POST;
        end else if (trig_evt) begin
          trig_pend_d = 1'b1;
        end
      end

      ST_POST: begin
        if (adc_valid) begin
          post_cnt_d = post_cnt_q + CNT_ONE;
          if (post_cnt_q + CNT_ONE == cfg_post_q) begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        // The buffer read lands directly in the output register, so a new word is
        // fetched only when that register is empty or being drained this cycle.
        rd_load = (rd_left_q != '0) && (!rd_valid_q || rd_ready);
        if (rd_load) begin
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_left_q == CNT_ONE);
          rd_addr_d  = rd_addr_q + PTR_ONE;
          rd_left_d  = rd_left_q - CNT_ONE;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rd_last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a coincident arm or final handshake.
    if (abort) begin
      state_d     = ST_IDLE;
      wptr_d      = wptr_q;
      trig_addr_d = trig_addr_q;
      trig_pend_d = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      done_d      = 1'b0;
      mem_we      = 1'b0;
      rd_load     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      cfg_src_q   <= '0;
      cfg_ch_q    <= '0;
      cfg_thr_q   <= '0;
      cfg_pre_q   <= '0;
      cfg_post_q  <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_pend_q <= 1'b0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      trig_addr_q <= '0;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      ext_s1_q    <= 1'b0;
      ext_s2_q    <= 1'b0;
      ext_s3_q    <= 1'b0;
      ext_evt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cfg_src_q   <= cfg_src_d;
      cfg_ch_q    <= cfg_ch_d;
      cfg_thr_q   <= cfg_thr_d;
      cfg_pre_q   <= cfg_pre_d;
      cfg_post_q  <= cfg_post_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_pend_q <= trig_pend_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      trig_addr_q <= trig_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      ext_s1_q    <= ext_s1_d;
      ext_s2_q    <= ext_s2_d;
      ext_s3_q    <= ext_s3_d;
      ext_evt_q   <= ext_evt_d;
    end
  end

  // Sample buffer; contents are not reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[wptr_q] <= adc_data;
    end
  end

  // Registered buffer read doubling as the output data register; it only updates on a fetch.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_load) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign trig_addr = trig_addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule
